// File: rtl/fp16_sumsq_accum_if.sv
// Stream handshake bundle for the FP16 sum-of-squares accumulator:
// sample input channel plus result output channel.
interface fp16_sumsq_accum_if #(
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_data;
  logic [CNT_W-1:0] out_count;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count
  );
endinterface

// File: rtl/fp16_sumsq_accum.sv
// Accumulates a frame of non-negative FP16 squares into a truncated FP16 sum
// using a four-cycle align/add/normalise sequence per sample.
//
// state | meaning
// IDLE  | waiting for a sample, in_ready high
// ALIGN | order operands by exponent, shift the smaller mantissa
// ADD   | add aligned mantissas
// NORM  | renormalise, saturate, commit accumulator
// DONE  | result presented until out_ready
module fp16_sumsq_accum #(
  parameter int CNT_W = 8
) (
  input logic               clk,
  input logic               rst,
  fp16_sumsq_accum_if.slave bus
);

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;

  state_t           state;
  logic [4:0]       acc_e, op_e, l_e, sum_e;
  logic [10:0]      acc_m, op_m, l_m, s_m;
  logic [11:0]      sum;
  logic             acc_zero, sat, op_zero, op_last, upd;
  logic [CNT_W-1:0] count;

  logic [4:0]  in_e;
  logic        op_big;
  logic [4:0]  d;
  logic [10:0] small_m, shifted;

  assign in_e    = bus.in_data[14:10];
  assign op_big  = op_e > acc_e;
  assign d       = op_big ? (op_e - acc_e) : (acc_e - op_e);
  assign small_m = op_big ? acc_m : op_m;
  assign shifted = (d >= 5'd11) ? 11'd0 : (small_m >> d);

  logic [5:0]  n_e6;
  logic [4:0]  n_e;
  logic [10:0] n_m;
  logic        n_sat;

  always_comb begin
    n_e6  = {1'b0, sum_e} + {5'd0, sum[11]};
    n_e   = n_e6[4:0];
    n_m   = sum[11] ? sum[11:1] : sum[10:0];
    n_sat = sat;
    if (!upd) begin
      n_e = acc_e;
      n_m = acc_m;
    end else if (n_e6 >= 6'd31) begin
      n_sat = 1'b1;
      n_e   = 5'd30;
      n_m   = 11'h7FF;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      bus.in_ready  <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= 16'h0000;
      bus.out_count <= '0;
      acc_e         <= 5'd0;
      acc_m         <= 11'd0;
      acc_zero      <= 1'b1;
      sat           <= 1'b0;
      op_e          <= 5'd0;
      op_m          <= 11'd0;
      op_zero       <= 1'b0;
      op_last       <= 1'b0;
      upd           <= 1'b0;
      l_e           <= 5'd0;
      l_m           <= 11'd0;
      s_m           <= 11'd0;
      sum           <= 12'd0;
      sum_e         <= 5'd0;
      count         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_ready && bus.in_valid) begin
            bus.in_ready <= 1'b0;
            op_last      <= bus.in_last;
            if (in_e == 5'd0) begin
              op_zero <= 1'b1;
              op_e    <= 5'd0;
              op_m    <= 11'd0;
            end else if (in_e == 5'd31) begin
              op_zero <= 1'b0;
              op_e    <= 5'd30;
              op_m    <= 11'h7FF;
            end else begin
              op_zero <= 1'b0;
              op_e    <= in_e;
              op_m    <= {1'b1, bus.in_data[9:0]};
            end
            if (count != {CNT_W{1'b1}})
              count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
            state <= ALIGN;
          end else begin
            bus.in_ready <= 1'b1;
          end
        end
        ALIGN: begin
          // skip paths still pass through ADD so every sample costs 4 cycles
          upd <= 1'b0;
          if (!(op_zero || sat)) begin
            if (acc_zero) begin
              acc_e    <= op_e;
              acc_m    <= op_m;
              acc_zero <= 1'b0;
            end else begin
              upd <= 1'b1;
              l_e <= op_big ? op_e : acc_e;
              l_m <= op_big ? op_m : acc_m;
              s_m <= shifted;
            end
          end
          state <= ADD;
        end
        ADD: begin
          sum   <= {1'b0, l_m} + {1'b0, s_m};
          sum_e <= l_e;
          state <= NORM;
        end
        NORM: begin
          acc_e <= n_e;
          acc_m <= n_m;
          sat   <= n_sat;
          if (op_last) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= acc_zero ? 16'h0000 : {1'b0, n_e, n_m[9:0]};
            bus.out_count <= count;
            state         <= DONE;
          end else begin
            bus.in_ready <= 1'b1;
            state        <= IDLE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= 16'h0000;
            bus.out_count <= '0;
            acc_e         <= 5'd0;
            acc_m         <= 11'd0;
            acc_zero      <= 1'b1;
            sat           <= 1'b0;
            count         <= '0;
            bus.in_ready  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_sumsq_accum.sv
// Bench for fp16_sumsq_accum: directed and random frames checked against a
// value-domain model of truncated FP16 accumulation.
module tb_fp16_sumsq_accum;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fp16_sumsq_accum_if #(.CNT_W(CNT_W)) bus ();
  fp16_sumsq_accum #(.CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] m_acc = 16'h0000;
  bit          m_sat = 1'b0;
  int          m_cnt = 0;
  logic [15:0] fq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Value in units of 2^-24 (smallest normal grid)
  function automatic longint val_of(input logic [15:0] h);
    int e;
    e = h[14:10];
    if (e == 0) return 0;
    return longint'({1'b1, h[9:0]}) << (e - 1);
  endfunction

  function automatic logic [15:0] enc(input longint v, output bit s);
    int p, e;
    longint m;
    p = 0;
    for (int i = 0; i < 63; i++) if (v[i]) p = i;
    e = p - 9;
    s = 1'b0;
    if (e >= 31) begin
      s = 1'b1;
      return 16'h7BFF;
    end
    m = v >>> (e - 1);
    return {1'b0, e[4:0], m[9:0]};
  endfunction

  task automatic model_reset();
    m_acc = 16'h0000;
    m_sat = 1'b0;
    m_cnt = 0;
  endtask

  task automatic model_add(input logic [15:0] x);
    logic [15:0] xs;
    int ex, ea, el;
    longint vl, vs, grid;
    bit s;
    xs = (x[14:10] == 5'd31) ? 16'h7BFF : {1'b0, x[14:0]};
    if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
    if (xs[14:10] == 5'd0 || m_sat) return;
    if (m_acc == 16'h0000) begin
      m_acc = xs;
      return;
    end
    ex = xs[14:10];
    ea = m_acc[14:10];
    if (ex > ea) begin
      el = ex; vl = val_of(xs); vs = val_of(m_acc);
    end else begin
      el = ea; vl = val_of(m_acc); vs = val_of(xs);
    end
    grid = longint'(1) << (el - 1);
    m_acc = enc(vl + (vs / grid) * grid, s);
    if (s) m_sat = 1'b1;
  endtask

  task automatic send(input logic [15:0] d, input logic l);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    while (!bus.in_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("accept_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;
    acc_cyc = cyc;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    model_add(d);
  endtask

  task automatic take(input string tag, input bit chk_lat);
    int n;
    n = 0;
    while (!bus.out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
    // out_valid registered at T3, so the consumer can take it at edge T4
    if (chk_lat) chk({tag, "_lat"}, cyc - acc_cyc, 32'd3);
    chk({tag, "_data"}, {16'd0, bus.out_data}, {16'd0, m_acc});
    chk({tag, "_count"}, {24'd0, bus.out_count}, m_cnt);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({tag, "_post_valid"}, {31'd0, bus.out_valid}, 32'd0);
    chk({tag, "_post_ready"}, {31'd0, bus.in_ready}, 32'd1);
    model_reset();
  endtask

  task automatic run(input string tag);
    for (int i = 0; i < fq.size(); i++) send(fq[i], i == fq.size() - 1);
    take(tag, 1'b1);
    fq.delete();
  endtask

  function automatic logic [15:0] rand_sample();
    logic [15:0] r;
    int k;
    r = 16'($urandom);
    k = $urandom_range(0, 9);
    if (k == 0) r[14:10] = 5'd0;
    else if (k == 1) r[14:10] = 5'd31;
    else r[14:10] = 5'($urandom_range(1, 30));
    return r;
  endfunction

  initial begin
    int a1;
    logic [15:0] hd;
    logic [7:0]  hc;
    bus.in_valid  = 1'b0;
    bus.in_data   = 16'h0000;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out_data", {16'd0, bus.out_data}, 32'd0);
    chk("rst_out_count", {24'd0, bus.out_count}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_ready_rise", {31'd0, bus.in_ready}, 32'd1);

    send(16'h3C00, 1'b0);
    a1 = acc_cyc;
    send(16'h3C00, 1'b1);
    chk("accept_gap", acc_cyc - a1, 32'd4);
    take("two_ones", 1'b1);
    chk("two_ones_const", {16'd0, m_acc}, 32'd0);

    fq = '{16'h3C00, 16'h3C00, 16'h3C00};
    run("three_ones");
    fq = '{16'h3C00, 16'h1400};
    run("d10");
    fq = '{16'h3C00, 16'h1000};
    run("d11");
    fq = '{16'h7BFF, 16'h7BFF, 16'h3C00};
    run("sat");
    fq = '{16'h0000};
    run("zero_single");
    fq = '{16'h4400};
    run("single_after_clear");
    fq = '{16'h7C00, 16'h8400, 16'h0123};
    run("exp31_sign_sub");

    for (int f = 0; f < 10; f++) begin
      int len;
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) fq.push_back(rand_sample());
      run("rand_frame");
    end

    for (int i = 0; i < 260; i++) fq.push_back(rand_sample());
    run("count_sat");

    send(16'h3C00, 1'b0);
    send(16'h3C00, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst_add_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("rst_add_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_add_out_count", {24'd0, bus.out_count}, 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    send(16'h4000, 1'b1);
    for (int n = 0; n < 40 && !bus.out_valid; n++) begin
      @(posedge clk); #1;
    end
    hd = bus.out_data;
    hc = bus.out_count;
    chk("hold_first_data", {16'd0, hd}, {16'd0, m_acc});
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("hold_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("hold_data", {16'd0, bus.out_data}, {16'd0, hd});
      chk("hold_count", {24'd0, bus.out_count}, {24'd0, hc});
    end
    take("post_reset", 1'b0);

    fq = '{16'h3C00, 16'h3800};
    for (int i = 0; i < fq.size(); i++) send(fq[i], i == fq.size() - 1);
    for (int n = 0; n < 40 && !bus.out_valid; n++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    chk("rst_done_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_done_out_data", {16'd0, bus.out_data}, 32'd0);
    chk("rst_done_out_count", {24'd0, bus.out_count}, 32'd0);
    fq.delete();
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    fq = '{16'h4000};
    run("after_done_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
